cva6_ptw_sv32_lite: RTL and testbench

- Sv32 page-table walker that sits directly upstream of cva6_tlb_sv32 and refills it.
- Accepts a TLB miss, walks the two-level page table over a simple memory request/response port, and emits one 63-bit update word in the TLB's update_i format.
- Reports a page-fault pulse on invalid or misaligned PTEs.
- Single outstanding walk; single outstanding memory access.

---
 rtl/cva6_ptw_sv32_lite_if.sv | 33 +++
 rtl/cva6_ptw_sv32_lite.sv | 125 ++++++++++++
 tb/tb_cva6_ptw_sv32_lite.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cva6_ptw_sv32_lite_if.sv
// rtl/cva6_ptw_sv32_lite_if.sv - miss, memory and refill signals of the Sv32 page-table walker
// slave is the walker's view; master is the view of the TLB/memory side that drives it.
interface cva6_ptw_sv32_lite_if #(
  parameter int unsigned ASID_WIDTH = 1
);
  logic                  flush_i;
  logic                  miss_valid_i;
  logic                  miss_ready_o;
  logic [31:0]           miss_vaddr_i;
  logic [ASID_WIDTH-1:0] miss_asid_i;
  logic [21:0]           satp_ppn_i;
  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [33:0]           mem_addr_o;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;
  logic [62:0]           update_o;
  logic                  walking_o;
  logic                  pf_o;
  logic [31:0]           pf_vaddr_o;

  modport slave (
    input  flush_i, miss_valid_i, miss_vaddr_i, miss_asid_i, satp_ppn_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output miss_ready_o, mem_req_o, mem_addr_o, update_o, walking_o, pf_o, pf_vaddr_o
  );

  modport master (
    output flush_i, miss_valid_i, miss_vaddr_i, miss_asid_i, satp_ppn_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  miss_ready_o, mem_req_o, mem_addr_o, update_o, walking_o, pf_o, pf_vaddr_o
  );
endinterface

// File: rtl/cva6_ptw_sv32_lite.sv
// rtl/cva6_ptw_sv32_lite.sv - two-level Sv32 page-table walker refilling cva6_tlb_sv32
// Define PTW_AD_CHECK_EN to fault on leaf PTEs whose accessed bit is clear.
module cva6_ptw_sv32_lite #(
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  cva6_ptw_sv32_lite_if.slave     ptw
);

`ifdef PTW_AD_CHECK_EN
  localparam logic AD_CHECK = 1'b1;
`else
  localparam logic AD_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, UPDATE, FAULT, DRAIN
  } state_t;

  state_t                state;
  logic [31:0]           vaddr_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic [21:0]           ppn_q;
  logic                  is_4m_q;
  logic [31:0]           pte_q;
  logic [31:0]           pf_vaddr_q;

  logic [31:0] pte;
  logic        pte_invalid;
  logic        pte_leaf;
  logic        pte_ad_fault;
  logic        pte_misaligned;

  assign pte            = ptw.mem_rdata_i;
  assign pte_invalid    = !pte[0] || (!pte[1] && pte[2]);
  assign pte_leaf       = pte[1] || pte[3];
  assign pte_ad_fault   = AD_CHECK && !pte[6];
  assign pte_misaligned = pte[19:10] != 10'd0;

  // Outputs decode only registered state; flush gates the ready and the refill word.
  assign ptw.miss_ready_o = (state == IDLE) && !ptw.flush_i;
  assign ptw.mem_req_o    = (state == L1_REQ) || (state == L0_REQ);
  assign ptw.mem_addr_o   = {ppn_q, (state == L0_REQ) ? vaddr_q[21:12] : vaddr_q[31:22], 2'b00};
  assign ptw.walking_o    = state != IDLE;
  assign ptw.pf_o         = state == FAULT;
  assign ptw.pf_vaddr_o   = pf_vaddr_q;
  assign ptw.update_o     = (state == UPDATE && !ptw.flush_i)
                          ? {1'b1, is_4m_q, vaddr_q[31:12], 9'(asid_q), pte_q}
                          : 63'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      vaddr_q    <= '0;
      asid_q     <= '0;
      ppn_q      <= '0;
      is_4m_q    <= 1'b0;
      pte_q      <= '0;
      pf_vaddr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ptw.miss_valid_i && !ptw.flush_i) begin
            vaddr_q <= ptw.miss_vaddr_i;
            asid_q  <= ptw.miss_asid_i;
            ppn_q   <= ptw.satp_ppn_i;
            state   <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          // A granted request owes us a response, so a flush must drain it.
          if (ptw.mem_gnt_i) begin
            if (ptw.flush_i)            state <= DRAIN;
            else if (state == L1_REQ)   state <= L1_WAIT;
            else                        state <= L0_WAIT;
          end else if (ptw.flush_i) begin
            state <= IDLE;
          end
        end
        L1_WAIT: begin
          if (ptw.mem_rvalid_i) begin
            if (ptw.flush_i) begin
              state <= IDLE;
            end else if (pte_invalid || (pte_leaf && (pte_misaligned || pte_ad_fault))) begin
              state      <= FAULT;
              pf_vaddr_q <= vaddr_q;
            end else if (pte_leaf) begin
              state   <= UPDATE;
              is_4m_q <= 1'b1;
              pte_q   <= pte;
            end else begin
              state <= L0_REQ;
              ppn_q <= pte[31:10];
            end
          end else if (ptw.flush_i) begin
            state <= DRAIN;
          end
        end
        L0_WAIT: begin
          if (ptw.mem_rvalid_i) begin
            if (ptw.flush_i) begin
              state <= IDLE;
            end else if (pte_invalid || !pte_leaf || pte_ad_fault) begin
              state      <= FAULT;
              pf_vaddr_q <= vaddr_q;
            end else begin
              state   <= UPDATE;
              is_4m_q <= 1'b0;
              pte_q   <= pte;
            end
          end else if (ptw.flush_i) begin
            state <= DRAIN;
          end
        end
        UPDATE, FAULT: state <= IDLE;
        DRAIN: begin
          if (ptw.mem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cva6_ptw_sv32_lite.sv
// tb/tb_cva6_ptw_sv32_lite.sv - directed vector bench for the Sv32 page-table walker
module tb_cva6_ptw_sv32_lite;
  localparam int AW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cva6_ptw_sv32_lite_if #(.ASID_WIDTH(AW)) ptw();
  cva6_ptw_sv32_lite #(.ASID_WIDTH(AW)) dut (.clk_i(clk), .rst_ni(rst_n), .ptw(ptw));

  typedef struct {
    logic [31:0]   va;
    logic [AW-1:0] asid;
    logic [21:0]   satp;
    logic [31:0]   p1;
    logic [31:0]   p0;
    int            stall;
    int            fl;
    int            nacc;
    logic [33:0]   a1;
    logic [33:0]   a0;
    logic [62:0]   upd;
    int            cyc;
    int            pf;
  } vec_t;

  vec_t        vt[10];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] pq[$];
  bit          pend = 0;
  int          stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Zero-wait memory: grant in the request cycle, data in the next one.
  task automatic mem_tick();
    ptw.mem_gnt_i = 1'b0;
    ptw.mem_rvalid_i = 1'b0;
    if (pend) begin
      ptw.mem_rvalid_i = 1'b1;
      if (pq.size() > 0) ptw.mem_rdata_i = pq.pop_front();
      else ptw.mem_rdata_i = 32'h0;
      pend = 0;
    end
    #1;
    if (ptw.mem_req_o) begin
      if (stall_left > 0) stall_left--;
      else begin
        ptw.mem_gnt_i = 1'b1;
        pend = 1;
      end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    int          n_acc, upd_cnt, upd_cyc, pf_cnt, stall_obs;
    logic [33:0] acc[2];
    logic [62:0] upd_val;
    logic [31:0] pfva;
    bit          done;
    v = vt[idx];
    n_acc = 0; upd_cnt = 0; upd_cyc = -1; pf_cnt = 0; stall_obs = 0; done = 0;
    acc[0] = '0; acc[1] = '0; upd_val = '0; pfva = '0;
    pq.delete(); pq.push_back(v.p1); pq.push_back(v.p0);
    pend = 0; stall_left = v.stall;
    @(negedge clk);
    ptw.miss_valid_i = 1'b1; ptw.miss_vaddr_i = v.va; ptw.miss_asid_i = v.asid; ptw.satp_ppn_i = v.satp;
    #1 chk($sformatf("v%0d accept_ready", idx), 64'(ptw.miss_ready_o), 64'd1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ptw.miss_valid_i = 1'b0;
      ptw.flush_i = (c == v.fl);
      mem_tick();
      if (ptw.update_o != 63'd0) begin
        upd_cnt++; upd_val = ptw.update_o; upd_cyc = c;
      end
      if (ptw.pf_o) begin
        pf_cnt++; pfva = ptw.pf_vaddr_o;
      end
      if (ptw.mem_gnt_i) begin
        if (n_acc < 2) acc[n_acc] = ptw.mem_addr_o;
        n_acc++;
      end else if (ptw.mem_req_o) begin
        stall_obs++;
        chk($sformatf("v%0d stall_addr", idx), 64'(ptw.mem_addr_o), 64'(v.a1));
      end
      if (!ptw.walking_o) begin
        done = 1;
        break;
      end
    end
    ptw.flush_i = 1'b0; ptw.mem_gnt_i = 1'b0; ptw.mem_rvalid_i = 1'b0; pend = 0;
    chk($sformatf("v%0d walk_done", idx), 64'(done), 64'd1);
    chk($sformatf("v%0d n_access", idx), 64'(n_acc), 64'(v.nacc));
    chk($sformatf("v%0d stall_cycles", idx), 64'(stall_obs), 64'(v.stall));
    if (v.nacc >= 1) chk($sformatf("v%0d l1_addr", idx), 64'(acc[0]), 64'(v.a1));
    if (v.nacc >= 2) chk($sformatf("v%0d l0_addr", idx), 64'(acc[1]), 64'(v.a0));
    chk($sformatf("v%0d update", idx), 64'(upd_val), 64'(v.upd));
    chk($sformatf("v%0d update_cycles", idx), 64'(upd_cnt), (v.upd[62] ? 64'd1 : 64'd0));
    if (v.upd[62]) chk($sformatf("v%0d latency", idx), 64'(upd_cyc), 64'(v.cyc));
    chk($sformatf("v%0d pf_pulses", idx), 64'(pf_cnt), 64'(v.pf));
    if (v.pf != 0) chk($sformatf("v%0d pf_vaddr", idx), 64'(pfva), 64'(v.va));
    #1 chk($sformatf("v%0d idle_ready", idx), 64'(ptw.miss_ready_o), 64'd1);
  endtask

  initial begin
    bit saw_upd, saw_pf;

    //         va            asid  satp       p1            p0            st fl na a1              a0            upd                                                     cyc pf
    vt[0] = '{32'h00403000, 1'b1, 22'h00001, 32'h00000801, 32'h000020CF, 0, 0, 2, 34'h000001004, 34'h00000200C, {1'b1, 1'b0, 20'h00403, 9'h001, 32'h000020CF}, 5, 0};
    vt[1] = '{32'h00800000, 1'b0, 22'h00001, 32'h004000CF, 32'h00000000, 0, 0, 1, 34'h000001008, 34'h0,         {1'b1, 1'b1, 20'h00800, 9'h000, 32'h004000CF}, 3, 0};
    vt[2] = '{32'h12345678, 1'b1, 22'h3ABCD, 32'h00000000, 32'h00000000, 0, 0, 1, 34'h03ABCD120, 34'h0,         63'd0, 0, 1};
    vt[3] = '{32'h00800000, 1'b0, 22'h00001, 32'h000004CF, 32'h00000000, 0, 0, 1, 34'h000001008, 34'h0,         63'd0, 0, 1};
    vt[4] = '{32'h00403000, 1'b1, 22'h00001, 32'h00000801, 32'h00000801, 0, 0, 2, 34'h000001004, 34'h00000200C, 63'd0, 0, 1};
    vt[5] = '{32'hFFC01000, 1'b0, 22'h00002, 32'h00000C01, 32'h000020CF, 4, 0, 2, 34'h000002FFC, 34'h000003004, {1'b1, 1'b0, 20'hFFC01, 9'h000, 32'h000020CF}, 9, 0};
`ifdef PTW_AD_CHECK_EN
    vt[6] = '{32'h00403000, 1'b1, 22'h00001, 32'h00000801, 32'h0000208F, 0, 0, 2, 34'h000001004, 34'h00000200C, 63'd0, 0, 1};
`else
    vt[6] = '{32'h00403000, 1'b1, 22'h00001, 32'h00000801, 32'h0000208F, 0, 0, 2, 34'h000001004, 34'h00000200C, {1'b1, 1'b0, 20'h00403, 9'h001, 32'h0000208F}, 5, 0};
`endif
    vt[7] = '{32'h00800000, 1'b0, 22'h00001, 32'h004000CF, 32'h00000000, 0, 3, 1, 34'h000001008, 34'h0,         63'd0, 0, 0};
    vt[8] = '{32'h00403000, 1'b1, 22'h00001, 32'h00000801, 32'h000020CF, 0, 4, 2, 34'h000001004, 34'h00000200C, 63'd0, 0, 0};
    vt[9] = '{32'h00403000, 1'b1, 22'h00001, 32'h00000801, 32'h000020CF, 1, 1, 0, 34'h000001004, 34'h0,         63'd0, 0, 0};

    ptw.flush_i = 0; ptw.miss_valid_i = 0; ptw.miss_vaddr_i = 0; ptw.miss_asid_i = 0;
    ptw.satp_ppn_i = 0; ptw.mem_gnt_i = 0; ptw.mem_rvalid_i = 0; ptw.mem_rdata_i = 0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst miss_ready", 64'(ptw.miss_ready_o), 64'd1);
    chk("rst mem_req", 64'(ptw.mem_req_o), 64'd0);
    chk("rst mem_addr", 64'(ptw.mem_addr_o), 64'd0);
    chk("rst update", 64'(ptw.update_o), 64'd0);
    chk("rst walking", 64'(ptw.walking_o), 64'd0);
    chk("rst pf", 64'(ptw.pf_o), 64'd0);
    chk("rst pf_vaddr", 64'(ptw.pf_vaddr_o), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Flush while idle blocks acceptance.
    @(negedge clk);
    ptw.miss_valid_i = 1; ptw.flush_i = 1; ptw.miss_vaddr_i = 32'h00403000;
    #1 chk("idle_flush ready", 64'(ptw.miss_ready_o), 64'd0);
    @(negedge clk);
    ptw.miss_valid_i = 0; ptw.flush_i = 0;
    #1 chk("idle_flush walking", 64'(ptw.walking_o), 64'd0);

    // Flush in L0_WAIT drains the outstanding response.
    pq.delete(); pq.push_back(32'h00000801); pend = 0; stall_left = 0;
    saw_upd = 0; saw_pf = 0;
    @(negedge clk);
    ptw.miss_valid_i = 1; ptw.miss_vaddr_i = 32'h00403000; ptw.satp_ppn_i = 22'h1; ptw.miss_asid_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ptw.miss_valid_i = 0;
      if (c == 4) pend = 0;
      ptw.flush_i = (c == 4);
      mem_tick();
      if (c == 7) begin
        ptw.mem_rvalid_i = 1; ptw.mem_rdata_i = 32'h000020CF;
      end
      if (ptw.update_o != 63'd0) saw_upd = 1;
      if (ptw.pf_o) saw_pf = 1;
      if (c == 5 || c == 6) begin
        chk($sformatf("drain c%0d walking", c), 64'(ptw.walking_o), 64'd1);
        chk($sformatf("drain c%0d ready", c), 64'(ptw.miss_ready_o), 64'd0);
      end
      if (c == 8) begin
        chk("drain done walking", 64'(ptw.walking_o), 64'd0);
        chk("drain done ready", 64'(ptw.miss_ready_o), 64'd1);
      end
    end
    ptw.flush_i = 0; ptw.mem_rvalid_i = 0; ptw.mem_gnt_i = 0; pend = 0;
    chk("drain no update", 64'(saw_upd), 64'd0);
    chk("drain no pf", 64'(saw_pf), 64'd0);

    // Back-to-back misses with miss_valid held high.
    pq.delete(); pq.push_back(32'h004000CF); pq.push_back(32'h00000000); pend = 0; stall_left = 0;
    @(negedge clk);
    ptw.miss_valid_i = 1; ptw.miss_vaddr_i = 32'h00800000; ptw.satp_ppn_i = 22'h1; ptw.miss_asid_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) ptw.miss_vaddr_i = 32'h00403000;
      if (c == 5) ptw.miss_valid_i = 0;
      mem_tick();
      if (c <= 3) chk($sformatf("b2b c%0d ready", c), 64'(ptw.miss_ready_o), 64'd0);
      if (c == 3) chk("b2b first update", 64'(ptw.update_o),
                      64'({1'b1, 1'b1, 20'h00800, 9'h000, 32'h004000CF}));
      if (c == 4) chk("b2b reaccept ready", 64'(ptw.miss_ready_o), 64'd1);
      if (c == 5) chk("b2b second addr", 64'(ptw.mem_addr_o), 64'h000001004);
      if (c == 7) begin
        chk("b2b second pf", 64'(ptw.pf_o), 64'd1);
        chk("b2b second pf_vaddr", 64'(ptw.pf_vaddr_o), 64'h00403000);
      end
      if (c == 10) chk("b2b idle", 64'(ptw.walking_o), 64'd0);
    end
    ptw.mem_gnt_i = 0; ptw.mem_rvalid_i = 0; pend = 0;

    // Asynchronous reset mid-walk; the late response must be ignored.
    saw_upd = 0; saw_pf = 0;
    pq.delete(); pend = 0; stall_left = 0;
    @(negedge clk);
    ptw.miss_valid_i = 1; ptw.miss_vaddr_i = 32'h00800000;
    @(negedge clk);
    ptw.miss_valid_i = 0;
    mem_tick();
    @(negedge clk);
    ptw.mem_gnt_i = 0; pend = 0;
    rst_n = 0;
    #1;
    chk("midrst walking", 64'(ptw.walking_o), 64'd0);
    chk("midrst mem_req", 64'(ptw.mem_req_o), 64'd0);
    chk("midrst ready", 64'(ptw.miss_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1;
    ptw.mem_rvalid_i = 1; ptw.mem_rdata_i = 32'h004000CF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ptw.mem_rvalid_i = 0;
      #1;
      if (ptw.update_o != 63'd0) saw_upd = 1;
      if (ptw.pf_o || ptw.walking_o) saw_pf = 1;
    end
    chk("midrst no update", 64'(saw_upd), 64'd0);
    chk("midrst stays idle", 64'(saw_pf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
